kgp_alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the KGP_RISC execute stage. It replaces the single-cycle combinational ALU with a valid/ready-handshaked unit. It keeps the operand-source selection (register b, shamt, offset) and the carry/zero/sign flags, and adds data-width parametrisation, arithmetic right shift, and iterative unsigned multiply, divide and remainder. Results and flags are registered and held until the downstream stage accepts them.

---
 rtl/kgp_alu_pkg.sv | 34 +++
 rtl/kgp_alu_iter.sv | 53 +++++
 rtl/kgp_alu_mc.sv | 150 +++++++++++++++
 tb/tb_kgp_alu_mc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_alu_pkg.sv
// Shared types for the KGP multi-cycle ALU: opcodes, B-operand sources and FSM states.
package kgp_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_MULU = 4'd8,
        OP_DIVU = 4'd9,
        OP_REMU = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        SRC_B      = 2'd0,
        SRC_SHAMT  = 2'd1,
        SRC_OFFSET = 2'd2
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_iter(input op_e op);
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/kgp_alu_iter.sv
// Shared iterative engine: radix-2 shift-add multiply or restoring divide, one bit per step.
module kgp_alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // acc_q holds the product high half / partial remainder; lo_q the multiplier / quotient.
    logic [WIDTH-1:0] acc_q, lo_q, opb_q;
    logic             div_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   sum_w, sh_w, diff_w;

    always_comb begin
        sum_w  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        sh_w   = {acc_q, lo_q[WIDTH-1]};
        diff_w = sh_w - {1'b0, opb_q};
        if (!div_q) begin
            hi_d = sum_w[WIDTH:1];
            lo_d = {sum_w[0], lo_q[WIDTH-1:1]};
        end else if (!diff_w[WIDTH]) begin
            hi_d = diff_w[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_d = sh_w[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            acc_q <= '0;
            lo_q  <= a_i;
            opb_q <= b_i;
            div_q <= div_i;
        end else if (step_i) begin
            acc_q <= hi_d;
            lo_q  <= lo_d;
        end
    end

    // Post-step values so the caller can capture the final iteration on the same edge.
    assign hi_o = hi_d;
    assign lo_o = lo_d;

endmodule

// File: rtl/kgp_alu_mc.sv
// Multi-cycle KGP execute ALU: single-cycle add/logic/shift plus iterative MULU/DIVU/REMU.
module kgp_alu_mc
    import kgp_alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] shamt,
    input  logic [WIDTH-1:0] offset,
    input  logic [1:0]       ALUsource,
    input  logic [3:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic             err
);

    state_e           state_q, state_d;
    op_e              op_in, op_q;
    logic [SHW-1:0]   cnt_q, amt;
    logic [WIDTH-1:0] bop, sc_res, fin_res, it_hi, it_lo;
    logic             sc_c, sc_e, fin_c, fin_e, bz_q, sub, accept;
    logic [WIDTH:0]   sum_w, shl_w, shr_w, sra_w;

    assign op_in  = op_e'(ALUop);
    assign accept = (state_q == ST_IDLE) && in_valid;
    assign amt    = bop[SHW-1:0];
    assign sub    = (op_in == OP_SUB);

    always_comb begin
        case (ALUsource)
            SRC_SHAMT:  bop = shamt;
            SRC_OFFSET: bop = offset;
            default:    bop = b;
        endcase
    end

    // Shifts run one bit wider so the last bit shifted out lands in the extra position.
    always_comb begin
        sum_w  = {1'b0, a} + {1'b0, sub ? ~bop : bop} + {{WIDTH{1'b0}}, sub};
        shl_w  = {1'b0, a} << amt;
        shr_w  = {a, 1'b0} >> amt;
        sra_w  = $signed({a, 1'b0}) >>> amt;
        sc_res = '0;
        sc_c   = 1'b0;
        sc_e   = 1'b0;
        case (op_in)
            OP_ADD, OP_SUB: {sc_c, sc_res} = sum_w;
            OP_AND:         sc_res = a & bop;
            OP_OR:          sc_res = a | bop;
            OP_XOR:         sc_res = a ^ bop;
            OP_SLL:         {sc_c, sc_res} = shl_w;
            OP_SRL:         {sc_res, sc_c} = shr_w;
            OP_SRA:         {sc_res, sc_c} = sra_w;
            OP_MULU, OP_DIVU, OP_REMU: sc_res = '0;
            default:        sc_e = 1'b1;
        endcase
    end

    kgp_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .start_i (accept && is_iter(op_in)),
        .step_i  (state_q == ST_BUSY),
        .div_i   (op_in != OP_MULU),
        .a_i     (a),
        .b_i     (bop),
        .hi_o    (it_hi),
        .lo_o    (it_lo)
    );

    always_comb begin
        fin_res = it_lo;
        fin_c   = 1'b0;
        fin_e   = 1'b0;
        case (op_q)
            OP_MULU: fin_c = |it_hi;
            OP_DIVU: fin_e = bz_q;
            OP_REMU: begin
                fin_res = it_hi;
                fin_e   = bz_q;
            end
            default: fin_res = it_lo;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = is_iter(op_in) ? ST_BUSY : ST_DONE;
            ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= OP_ADD;
            bz_q   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            sign   <= 1'b0;
            err    <= 1'b0;
        end else if (accept) begin
            op_q <= op_in;
            bz_q <= (bop == '0);
            if (is_iter(op_in)) begin
                cnt_q <= SHW'(WIDTH - 1);
            end else begin
                result <= sc_res;
                carry  <= sc_c;
                zero   <= (sc_res == '0);
                sign   <= sc_res[WIDTH-1];
                err    <= sc_e;
            end
        end else if (state_q == ST_BUSY) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                result <= fin_res;
                carry  <= fin_c;
                zero   <= (fin_res == '0);
                sign   <= fin_res[WIDTH-1];
                err    <= fin_e;
            end
        end
    end

endmodule

// File: tb/tb_kgp_alu_mc.sv
// Directed bench for kgp_alu_mc at WIDTH=32 with hand-computed expected values.
module tb_kgp_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0, shamt = '0, offset = '0;
    logic [1:0]  ALUsource = 2'd0;
    logic [3:0]  ALUop = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry, zero, sign, err;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;

    kgp_alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .shamt(shamt), .offset(offset),
        .ALUsource(ALUsource), .ALUop(ALUop),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry(carry), .zero(zero), .sign(sign), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] r,
                           input logic c, input logic z, input logic s, input logic e);
        chk({tag, ".result"}, result, r);
        chk({tag, ".carry"}, {31'd0, carry}, {31'd0, c});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
        chk({tag, ".sign"}, {31'd0, sign}, {31'd0, s});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, e});
    endtask

    task automatic run_op(input logic [3:0] op, input logic [1:0] src,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] sv, input logic [31:0] ov,
                          output int cyc);
        @(negedge clk);
        ALUop = op; ALUsource = src; a = av; b = bv; shamt = sv; offset = ov;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk_out("rst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        run_op(4'd0, 2'b00, 32'd32, 32'd16, 32'd0, 32'd0, lat);
        chk("add.lat", lat, 32'd0);
        chk("add.in_ready", {31'd0, in_ready}, 32'd0);
        chk_out("add", 32'd48, 1'b0, 1'b0, 1'b0, 1'b0);
        release_out();
        chk("add.rel_valid", {31'd0, out_valid}, 32'd0);
        chk("add.rel_ready", {31'd0, in_ready}, 32'd1);

        run_op(4'd0, 2'b10, 32'd32, 32'd16, 32'd0, 32'd10, lat);
        chk_out("add_off", 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(4'd0, 2'b11, 32'd7, 32'd3, 32'd100, 32'd200, lat);
        chk_out("add_src11", 32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(4'd1, 2'b00, 32'd16, 32'd32, 32'd0, 32'd0, lat);
        chk_out("sub_neg", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, 1'b0);
        release_out();

        run_op(4'd1, 2'b00, 32'd5, 32'd5, 32'd0, 32'd0, lat);
        chk_out("sub_eq", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        release_out();

        run_op(4'd4, 2'b00, 32'hF0F0_00FF, 32'h0FF0_00F0, 32'd0, 32'd0, lat);
        chk_out("xor", 32'hFF00_000F, 1'b0, 1'b0, 1'b1, 1'b0);
        release_out();

        run_op(4'd7, 2'b01, 32'h8000_0000, 32'd0, 32'd4, 32'd0, lat);
        chk_out("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        release_out();

        run_op(4'd5, 2'b01, 32'h8000_0001, 32'd0, 32'd1, 32'd0, lat);
        chk_out("sll", 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(4'd6, 2'b01, 32'h0000_0013, 32'd0, 32'd2, 32'd0, lat);
        chk_out("srl", 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(4'd6, 2'b01, 32'h8000_0001, 32'd0, 32'd0, 32'd0, lat);
        chk_out("srl0", 32'h8000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        release_out();

        run_op(4'd12, 2'b00, 32'd9, 32'd9, 32'd0, 32'd0, lat);
        chk("illegal.lat", lat, 32'd0);
        chk_out("illegal", 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        release_out();

        run_op(4'd8, 2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 32'd0, lat);
        chk("mulu.lat", lat, 32'd32);
        chk_out("mulu", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        release_out();

        run_op(4'd8, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, lat);
        chk_out("mulu_ovf", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        release_out();

        run_op(4'd8, 2'b10, 32'd1234, 32'd0, 32'd0, 32'd5678, lat);
        chk_out("mulu_off", 32'd7006652, 1'b0, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(4'd10, 2'b00, 32'd100, 32'd7, 32'd0, 32'd0, lat);
        chk("remu.lat", lat, 32'd32);
        chk_out("remu", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(4'd9, 2'b00, 32'd100, 32'd7, 32'd0, 32'd0, lat);
        chk("divu.lat", lat, 32'd32);
        chk_out("divu", 32'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        // Backpressure: hold out_ready low and poke in_valid with an ADD.
        ALUop = 4'd0; ALUsource = 2'b00; a = 32'd1; b = 32'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
            chk_out("bp", 32'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        release_out();
        chk("bp.rel_ready", {31'd0, in_ready}, 32'd1);
        chk("bp.rel_valid", {31'd0, out_valid}, 32'd0);

        run_op(4'd9, 2'b00, 32'hFFFF_FFFE, 32'h0000_0010, 32'd0, 32'd0, lat);
        chk_out("divu_big", 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        release_out();

        run_op(4'd9, 2'b00, 32'd100, 32'd0, 32'd0, 32'd0, lat);
        chk("divz.lat", lat, 32'd32);
        chk_out("divz", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        release_out();

        run_op(4'd10, 2'b00, 32'd100, 32'd0, 32'd0, 32'd0, lat);
        chk("remz.lat", lat, 32'd32);
        chk_out("remz", 32'd100, 1'b0, 1'b0, 1'b0, 1'b1);
        release_out();

        // Abort a MULU with reset in its 10th BUSY cycle.
        @(negedge clk);
        ALUop = 4'd8; ALUsource = 2'b00; a = 32'd3; b = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("abort.busy_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort.in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
        chk_out("abort", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abort.no_valid", seen, 32'd0);

        run_op(4'd0, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0, lat);
        chk("post_rst.lat", lat, 32'd0);
        chk_out("post_rst", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        release_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
